// File: rtl/start_fifo_srl_ctrl.sv
// First-word-fall-through shift-register FIFO controller for dataflow start channels.
// Writes shift into slot 0; the head of queue is always slot count-1.
module start_fifo_srl_ctrl #(
   parameter int unsigned DATA_WIDTH = 1,
   parameter int unsigned ADDR_WIDTH = 1,
   parameter int unsigned DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   output logic                  if_full_n,
   input  logic                  if_write_ce,
   input  logic                  if_write,
   input  logic [DATA_WIDTH-1:0] if_din,
   output logic                  if_empty_n,
   input  logic                  if_read_ce,
   input  logic                  if_read,
   output logic [DATA_WIDTH-1:0] if_dout,
   output logic [ADDR_WIDTH:0]   if_num_data_valid,
   output logic [ADDR_WIDTH:0]   if_fifo_cap
);

   localparam int unsigned CW = ADDR_WIDTH + 1;

   logic [CW-1:0]         count_q;
   logic [CW-1:0]         count_d;
   logic                  empty_n_q;
   logic                  full_n_q;
   logic [DATA_WIDTH-1:0] slot_q [DEPTH];
   logic                  push;
   logic                  pop;
   logic [ADDR_WIDTH-1:0] raddr;
   logic [DATA_WIDTH-1:0] dout_c;

   // Qualified handshakes: requests against a full/empty FIFO are dropped.
   assign push = if_write & if_write_ce & full_n_q;
   assign pop  = if_read  & if_read_ce  & empty_n_q;

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Flags are computed from the next count so they are valid right after the edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q   <= '0;
         empty_n_q <= 1'b0;
         full_n_q  <= 1'b1;
      end else begin
         count_q   <= count_d;
         empty_n_q <= (count_d != '0);
         full_n_q  <= (count_d != CW'(DEPTH));
      end
   end

   // Storage carries no reset; stale entries are never addressed once count drops.
   always_ff @(posedge clk) begin
      if (push) begin
         for (int i = int'(DEPTH) - 1; i > 0; i--) begin
            slot_q[i] <= slot_q[i-1];
         end
         slot_q[0] <= if_din;
      end
   end

   assign raddr = ADDR_WIDTH'(count_q - CW'(1));

   always_comb begin
      dout_c = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (raddr == ADDR_WIDTH'(i)) dout_c = slot_q[i];
      end
   end

   assign if_dout           = dout_c;
   assign if_full_n         = full_n_q;
   assign if_empty_n        = empty_n_q;
   assign if_num_data_valid = count_q;
   assign if_fifo_cap       = CW'(DEPTH);

endmodule

// File: tb/tb_start_fifo_srl_ctrl.sv
// Self-checking bench for start_fifo_srl_ctrl: vector table on a DEPTH=4 instance with a data
// scoreboard, plus hand sequences for mid-stream reset (DEPTH=2) and the DEPTH=1 corner.
module tb_start_fifo_srl_ctrl;

   logic clk;
   logic reset_n;

   // DEPTH=4, DATA_WIDTH=8
   logic       d4_full_n, d4_empty_n, d4_wce, d4_w, d4_rce, d4_r;
   logic [7:0] d4_din, d4_dout;
   logic [2:0] d4_cnt, d4_cap;
   // DEPTH=2, DATA_WIDTH=8
   logic       d2_full_n, d2_empty_n, d2_wce, d2_w, d2_rce, d2_r;
   logic [7:0] d2_din, d2_dout;
   logic [1:0] d2_cnt, d2_cap;
   // DEPTH=1, DATA_WIDTH=4
   logic       d1_full_n, d1_empty_n, d1_wce, d1_w, d1_rce, d1_r;
   logic [3:0] d1_din, d1_dout;
   logic [1:0] d1_cnt, d1_cap;

   start_fifo_srl_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4)) u_d4 (
      .clk(clk), .reset_n(reset_n), .if_full_n(d4_full_n), .if_write_ce(d4_wce),
      .if_write(d4_w), .if_din(d4_din), .if_empty_n(d4_empty_n), .if_read_ce(d4_rce),
      .if_read(d4_r), .if_dout(d4_dout), .if_num_data_valid(d4_cnt), .if_fifo_cap(d4_cap));

   start_fifo_srl_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(1), .DEPTH(2)) u_d2 (
      .clk(clk), .reset_n(reset_n), .if_full_n(d2_full_n), .if_write_ce(d2_wce),
      .if_write(d2_w), .if_din(d2_din), .if_empty_n(d2_empty_n), .if_read_ce(d2_rce),
      .if_read(d2_r), .if_dout(d2_dout), .if_num_data_valid(d2_cnt), .if_fifo_cap(d2_cap));

   start_fifo_srl_ctrl #(.DATA_WIDTH(4), .ADDR_WIDTH(1), .DEPTH(1)) u_d1 (
      .clk(clk), .reset_n(reset_n), .if_full_n(d1_full_n), .if_write_ce(d1_wce),
      .if_write(d1_w), .if_din(d1_din), .if_empty_n(d1_empty_n), .if_read_ce(d1_rce),
      .if_read(d1_r), .if_dout(d1_dout), .if_num_data_valid(d1_cnt), .if_fifo_cap(d1_cap));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       w;
      logic       wce;
      logic [7:0] din;
      logic       r;
      logic       rce;
      int         cnt;
      logic       full_n;
      logic       empty_n;
   } vec_t;

   vec_t       vecs[$];
   logic [7:0] sb[$];
   int         checks   = 0;
   int         failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic w, input logic wce, input logic [7:0] din,
                               input logic r, input logic rce, input int cnt,
                               input logic fn, input logic en);
      vec_t v;
      v.w = w; v.wce = wce; v.din = din; v.r = r; v.rce = rce;
      v.cnt = cnt; v.full_n = fn; v.empty_n = en;
      return v;
   endfunction

   initial begin
      reset_n = 1'b0;
      {d4_w, d4_wce, d4_r, d4_rce, d4_din} = '0;
      {d2_w, d2_wce, d2_r, d2_rce, d2_din} = '0;
      {d1_w, d1_wce, d1_r, d1_rce, d1_din} = '0;

      // Fill/drain, overflow/underflow, concurrent, CE gating, blocked push/pop corners
      vecs.push_back(mk(1,1,8'h11,0,0,1,1,1));
      vecs.push_back(mk(1,1,8'h22,0,0,2,1,1));
      vecs.push_back(mk(1,1,8'h33,0,0,3,1,1));
      vecs.push_back(mk(1,1,8'h44,0,0,4,0,1));
      vecs.push_back(mk(1,1,8'h55,0,0,4,0,1));
      vecs.push_back(mk(0,0,8'h00,1,1,3,1,1));
      vecs.push_back(mk(0,0,8'h00,1,1,2,1,1));
      vecs.push_back(mk(0,0,8'h00,1,1,1,1,1));
      vecs.push_back(mk(0,0,8'h00,1,1,0,1,0));
      vecs.push_back(mk(0,0,8'h00,1,1,0,1,0));
      vecs.push_back(mk(1,1,8'hA0,0,0,1,1,1));
      vecs.push_back(mk(1,1,8'hA1,0,0,2,1,1));
      vecs.push_back(mk(1,1,8'hA2,1,1,2,1,1));
      vecs.push_back(mk(0,0,8'h00,1,1,1,1,1));
      vecs.push_back(mk(0,0,8'h00,1,1,0,1,0));
      vecs.push_back(mk(1,0,8'h99,0,0,0,1,0));
      vecs.push_back(mk(1,1,8'h5A,0,0,1,1,1));
      vecs.push_back(mk(0,0,8'h00,1,0,1,1,1));
      vecs.push_back(mk(1,0,8'h98,1,0,1,1,1));
      vecs.push_back(mk(0,0,8'h00,1,1,0,1,0));
      vecs.push_back(mk(1,1,8'h66,1,1,1,1,1));
      vecs.push_back(mk(0,0,8'h00,1,1,0,1,0));
      vecs.push_back(mk(1,1,8'h77,0,0,1,1,1));
      vecs.push_back(mk(1,1,8'h78,0,0,2,1,1));
      vecs.push_back(mk(1,1,8'h79,0,0,3,1,1));
      vecs.push_back(mk(1,1,8'h7A,0,0,4,0,1));
      vecs.push_back(mk(1,1,8'h7B,1,1,3,1,1));
      vecs.push_back(mk(0,0,8'h00,1,1,2,1,1));
      vecs.push_back(mk(0,0,8'h00,1,1,1,1,1));
      vecs.push_back(mk(0,0,8'h00,1,1,0,1,0));

      repeat (2) @(posedge clk);
      #1;
      chk("rst_cnt",     32'(d4_cnt),     32'd0);
      chk("rst_full_n",  32'(d4_full_n),  32'd1);
      chk("rst_empty_n", 32'(d4_empty_n), 32'd0);
      chk("fifo_cap",    32'(d4_cap),     32'd4);
      chk("d1_rst_compl", 32'(d1_full_n ^ d1_empty_n), 32'd1);
      @(negedge clk);
      reset_n = 1'b1;

      // Scoreboard: accepted writes enqueue data, accepted reads compare the head
      foreach (vecs[k]) begin
         bit wacc, racc;
         @(negedge clk);
         d4_w = vecs[k].w; d4_wce = vecs[k].wce; d4_din = vecs[k].din;
         d4_r = vecs[k].r; d4_rce = vecs[k].rce;
         wacc = vecs[k].w && vecs[k].wce && (sb.size() < 4);
         racc = vecs[k].r && vecs[k].rce && (sb.size() > 0);
         #1;
         if (racc) chk($sformatf("v%0d_dout", k), 32'(d4_dout), 32'(sb.pop_front()));
         if (wacc) sb.push_back(vecs[k].din);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_cnt", k),     32'(d4_cnt),     32'(vecs[k].cnt));
         chk($sformatf("v%0d_full_n", k),  32'(d4_full_n),  32'(vecs[k].full_n));
         chk($sformatf("v%0d_empty_n", k), 32'(d4_empty_n), 32'(vecs[k].empty_n));
      end
      @(negedge clk);
      {d4_w, d4_wce, d4_r, d4_rce} = '0;
      chk("sb_drained", 32'(sb.size()), 32'd0);

      // DEPTH=1: single push fills, push+pop only pops
      d1_w = 1'b1; d1_wce = 1'b1; d1_din = 4'h7;
      @(posedge clk); #1;
      chk("d1_full_n",  32'(d1_full_n),  32'd0);
      chk("d1_empty_n", 32'(d1_empty_n), 32'd1);
      chk("d1_dout",    32'(d1_dout),    32'h7);
      chk("d1_cnt",     32'(d1_cnt),     32'd1);
      @(negedge clk);
      d1_din = 4'h8; d1_r = 1'b1; d1_rce = 1'b1;
      @(posedge clk); #1;
      chk("d1_pp_cnt",     32'(d1_cnt),     32'd0);
      chk("d1_pp_full_n",  32'(d1_full_n),  32'd1);
      chk("d1_pp_empty_n", 32'(d1_empty_n), 32'd0);
      @(negedge clk);
      {d1_w, d1_wce, d1_r, d1_rce} = '0;

      // DEPTH=2: fill, then asynchronous reset between edges
      d2_w = 1'b1; d2_wce = 1'b1; d2_din = 8'hC1;
      @(negedge clk);
      d2_din = 8'hC2;
      @(posedge clk); #1;
      chk("d2_full_before", 32'(d2_full_n), 32'd0);
      chk("d2_cnt_before",  32'(d2_cnt),    32'd2);
      d2_w = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      chk("d2_rst_cnt",     32'(d2_cnt),     32'd0);
      chk("d2_rst_full_n",  32'(d2_full_n),  32'd1);
      chk("d2_rst_empty_n", 32'(d2_empty_n), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      d2_w = 1'b1; d2_din = 8'hD5;
      @(posedge clk); #1;
      chk("d2_post_cnt",     32'(d2_cnt),     32'd1);
      chk("d2_post_empty_n", 32'(d2_empty_n), 32'd1);
      chk("d2_post_dout",    32'(d2_dout),    32'hD5);
      @(negedge clk);
      d2_w = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
